// File: rtl/pwm_multich_gen.sv
`default_nettype none
// ============================================================================
// Module   : pwm_multich_gen
// Purpose  : Multi-channel PWM generator. A shared prescaler and period
//            counter (edge- or center-aligned) drive NCH comparator channels.
//            Duty values are double-buffered: writes land in a shadow
//            register and are promoted to the active copy only at a period
//            boundary, so a running period never glitches.
// Ports    : clk          - single clock
//            rst_n        - asynchronous reset, ACTIVE HIGH (legacy name)
//            ena          - count enable; 0 freezes prescaler and counter
//            cfg_div      - prescaler terminal value (tick every cfg_div+1)
//            cfg_period   - period top value P, sampled at a boundary
//            cfg_center   - 0 = edge-aligned, 1 = center-aligned (boundary)
//            cfg_pol      - per-channel output inversion
//            wr_en/wr_ch/wr_duty - duty write port into the shadow registers
//            pwm_out      - registered PWM outputs
//            period_done  - registered one-clock pulse after each boundary
// Revision : 1.0 - initial release
// ============================================================================
module pwm_multich_gen #(
    parameter  int NCH   = 4,
    parameter  int CNT_W = 8,
    parameter  int DIV_W = 24,
    localparam int CH_W  = $clog2(NCH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic [DIV_W-1:0] cfg_div,
    input  logic [CNT_W-1:0] cfg_period,
    input  logic             cfg_center,
    input  logic [NCH-1:0]   cfg_pol,
    input  logic             wr_en,
    input  logic [CH_W-1:0]  wr_ch,
    input  logic [CNT_W-1:0] wr_duty,
    output logic [NCH-1:0]   pwm_out,
    output logic             period_done
);

    localparam logic [CNT_W-1:0] c_CNT_ZERO = '0;
    localparam logic [CNT_W-1:0] c_CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [DIV_W-1:0] r_pre_cnt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_act_p;
    logic             r_act_mode;   // 0 = edge, 1 = center
    logic             r_dir;        // 0 = counting up, 1 = counting down
    logic             r_period_done;

    logic             w_tick;
    logic             w_last;
    logic             w_bnd;

    // The >= compare lets pre_cnt recover on the next enabled cycle when
    // cfg_div is lowered below the running count.
    assign w_tick = ena & (r_pre_cnt >= cfg_div);

    // Last state of the counting sequence. The P==1 center case is an up
    // state: the sequence is just 0,1 so the turn-around at P is also the end.
    always_comb begin
        w_last = 1'b0;
        if (r_act_p == c_CNT_ZERO) begin
            w_last = 1'b1;
        end else if (!r_act_mode) begin
            w_last = (r_cnt == r_act_p);
        end else if (r_dir) begin
            w_last = (r_cnt <= c_CNT_ONE);
        end else begin
            w_last = (r_act_p == c_CNT_ONE) && (r_cnt == c_CNT_ONE);
        end
    end

    assign w_bnd = w_tick & w_last;

    // Prescaler
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            r_pre_cnt <= '0;
        end else if (ena) begin
            if (r_pre_cnt >= cfg_div) begin
                r_pre_cnt <= '0;
            end else begin
                r_pre_cnt <= r_pre_cnt + 1'b1;
            end
        end
    end

    // Period counter and boundary-loaded configuration
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            r_cnt         <= '0;
            r_dir         <= 1'b0;
            r_act_p       <= '0;
            r_act_mode    <= 1'b0;
            r_period_done <= 1'b0;
        end else begin
            r_period_done <= w_bnd;
            if (w_bnd) begin
                r_cnt      <= '0;
                r_dir      <= 1'b0;
                r_act_p    <= cfg_period;
                r_act_mode <= cfg_center;
            end else if (w_tick) begin
                if (!r_act_mode) begin
                    r_cnt <= r_cnt + 1'b1;
                end else if (!r_dir) begin
                    if (r_cnt == r_act_p) begin
                        r_dir <= 1'b1;
                        r_cnt <= r_cnt - 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end else begin
                    r_cnt <= r_cnt - 1'b1;
                end
            end
        end
    end

    assign period_done = r_period_done;

    // Per-channel shadow/active duty and output compare. A channel index
    // outside 0..NCH-1 matches no channel, so such writes are dropped.
    generate
        for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
            logic [CNT_W-1:0] r_shadow;
            logic [CNT_W-1:0] r_active;
            logic             r_pwm;

            always_ff @(posedge clk or posedge rst_n) begin
                if (rst_n) begin
                    r_shadow <= '0;
                    r_active <= '0;
                    r_pwm    <= 1'b0;
                end else begin
                    if (wr_en && (wr_ch == CH_W'(gi))) begin
                        r_shadow <= wr_duty;
                    end
                    // Old shadow value is promoted even if a write to it
                    // lands in the same cycle.
                    if (w_bnd) begin
                        r_active <= r_shadow;
                    end
                    r_pwm <= cfg_pol[gi] ^ (r_cnt < r_active);
                end
            end

            assign pwm_out[gi] = r_pwm;
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_pwm_multich_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_pwm_multich_gen
// Purpose  : Self-checking bench for pwm_multich_gen. A phase-index reference
//            model (position within the period, cnt derived arithmetically)
//            is compared against the DUT every clock, alongside directed
//            duty/period measurements.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pwm_multich_gen;

    localparam int NCH   = 6;
    localparam int CNT_W = 8;
    localparam int DIV_W = 8;
    localparam int CH_W  = $clog2(NCH);

    logic             clk = 1'b0;
    logic             rst;
    logic             ena;
    logic [DIV_W-1:0] cfg_div;
    logic [CNT_W-1:0] cfg_period;
    logic             cfg_center;
    logic [NCH-1:0]   cfg_pol;
    logic             wr_en;
    logic [CH_W-1:0]  wr_ch;
    logic [CNT_W-1:0] wr_duty;
    logic [NCH-1:0]   pwm_out;
    logic             period_done;

    always #5 clk = ~clk;

    pwm_multich_gen #(
        .NCH   (NCH),
        .CNT_W (CNT_W),
        .DIV_W (DIV_W)
    ) u_dut (
        .clk         (clk),
        .rst_n       (rst),
        .ena         (ena),
        .cfg_div     (cfg_div),
        .cfg_period  (cfg_period),
        .cfg_center  (cfg_center),
        .cfg_pol     (cfg_pol),
        .wr_en       (wr_en),
        .wr_ch       (wr_ch),
        .wr_duty     (wr_duty),
        .pwm_out     (pwm_out),
        .period_done (period_done)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: position k within the period, period length L.
    // ------------------------------------------------------------------
    function automatic int plen(input int p, input logic center);
        if (!center) return p + 1;
        if (p == 0) return 1;
        return 2 * p;
    endfunction

    function automatic int cval(input int k, input int p, input logic center);
        if (!center || k <= p) return k;
        return 2 * p - k;
    endfunction

    int             m_pre, m_k, m_P;
    logic           m_mode;
    int             m_sh  [NCH];
    int             m_act [NCH];
    logic [NCH-1:0] m_pwm;
    logic           m_done;
    logic           m_tick;
    logic           m_end;
    int             m_cnt;

    always_comb begin
        m_tick = ena && (m_pre >= int'(cfg_div));
        m_end  = (m_k == plen(m_P, m_mode) - 1);
        m_cnt  = cval(m_k, m_P, m_mode);
    end

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_pre  <= 0;
            m_k    <= 0;
            m_P    <= 0;
            m_mode <= 1'b0;
            m_pwm  <= '0;
            m_done <= 1'b0;
            for (int i = 0; i < NCH; i++) begin
                m_sh[i]  <= 0;
                m_act[i] <= 0;
            end
        end else begin
            m_done <= m_tick && m_end;
            for (int i = 0; i < NCH; i++) begin
                m_pwm[i] <= cfg_pol[i] ^ (m_cnt < m_act[i]);
            end
            if (ena) m_pre <= (m_pre >= int'(cfg_div)) ? 0 : m_pre + 1;
            if (m_tick) begin
                if (m_end) begin
                    m_k    <= 0;
                    m_P    <= int'(cfg_period);
                    m_mode <= cfg_center;
                    for (int i = 0; i < NCH; i++) m_act[i] <= m_sh[i];
                end else begin
                    m_k <= m_k + 1;
                end
            end
            if (wr_en && int'(wr_ch) < NCH) m_sh[wr_ch] <= int'(wr_duty);
        end
    end

    logic chk_en = 1'b0;

    always @(negedge clk) begin
        if (chk_en && !rst) begin
            check_val("model_pwm", 32'(pwm_out), 32'(m_pwm));
            check_val("model_done", 32'(period_done), 32'(m_done));
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers (all driven on the falling edge)
    // ------------------------------------------------------------------
    int hcnt [NCH];
    int dcnt;

    task automatic tick_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wr(input int ch, input int d);
        wr_en   = 1'b1;
        wr_ch   = CH_W'(ch);
        wr_duty = CNT_W'(d);
        @(negedge clk);
        wr_en   = 1'b0;
    endtask

    task automatic count_win(input int n);
        for (int i = 0; i < NCH; i++) hcnt[i] = 0;
        dcnt = 0;
        repeat (n) begin
            @(negedge clk);
            for (int i = 0; i < NCH; i++) hcnt[i] += int'(pwm_out[i]);
            dcnt += int'(period_done);
        end
    endtask

    task automatic wait_done();
        int t;
        t = 0;
        while (t < 300) begin
            @(negedge clk);
            if (period_done === 1'b1) break;
            t++;
        end
        if (t >= 300) check_val("done_timeout", 32'(period_done), 32'd1);
    endtask

    task automatic gap_to_done(output int g);
        g = 0;
        do begin
            @(negedge clk);
            g++;
        end while (period_done !== 1'b1 && g < 400);
    endtask

    int             h, g;
    logic [NCH-1:0] snap;

    initial begin
        rst = 1'b1; ena = 1'b0; cfg_div = '0; cfg_period = '0; cfg_center = 1'b0;
        cfg_pol = '0; wr_en = 1'b0; wr_ch = '0; wr_duty = '0;
        tick_n(3);
        check_val("rst_pwm", 32'(pwm_out), 32'd0);
        check_val("rst_done", 32'(period_done), 32'd0);
        rst = 1'b0;
        chk_en = 1'b1;

        // Edge mode, basic duty
        cfg_period = 8'd9;
        cfg_pol    = 6'b001000;
        wr(0, 3); wr(1, 0); wr(2, 10); wr(3, 5);
        ena = 1'b1;
        tick_n(30);
        count_win(10);
        check_val("edge_ch0", hcnt[0], 3);
        check_val("edge_ch1", hcnt[1], 0);
        check_val("edge_ch2", hcnt[2], 10);
        check_val("edge_ch3", hcnt[3], 5);
        check_val("edge_done", dcnt, 1);
        wait_done();
        gap_to_done(g);
        check_val("edge_gap", g, 10);

        // Prescaler
        cfg_div = 8'd4;
        tick_n(120);
        count_win(50);
        check_val("pre_ch0", hcnt[0], 15);
        check_val("pre_done", dcnt, 1);
        wait_done();
        gap_to_done(g);
        check_val("pre_gap", g, 50);

        // Center mode
        cfg_div    = 8'd0;
        cfg_center = 1'b1;
        cfg_period = 8'd8;
        wr(0, 4);
        tick_n(50);
        count_win(16);
        check_val("ctr_ch0", hcnt[0], 7);
        check_val("ctr_ch2", hcnt[2], 16);
        check_val("ctr_ch3", hcnt[3], 7);
        check_val("ctr_done", dcnt, 1);
        wait_done();
        gap_to_done(g);
        check_val("ctr_gap", g, 16);

        // Shadow timing
        cfg_center = 1'b0;
        cfg_period = 8'd9;
        wr(0, 3);
        tick_n(40);
        wait_done();
        h = 0;
        for (int j = 1; j <= 10; j++) begin
            @(negedge clk);
            h += int'(pwm_out[0]);
            if (j == 4) begin wr_en = 1'b1; wr_ch = 3'd0; wr_duty = 8'd7; end
            if (j == 5) wr_en = 1'b0;
        end
        check_val("shd_mid_old", h, 3);
        check_val("shd_done_align", 32'(period_done), 32'd1);
        h = 0;
        for (int j = 1; j <= 10; j++) begin
            @(negedge clk);
            h += int'(pwm_out[0]);
            if (j == 3) begin wr_en = 1'b1; wr_ch = 3'd6; wr_duty = 8'd0; end
            if (j == 4) wr_en = 1'b0;
        end
        check_val("shd_mid_new", h, 7);
        h = 0;
        for (int j = 1; j <= 10; j++) begin
            @(negedge clk);
            h += int'(pwm_out[0]);
            if (j == 9) begin wr_en = 1'b1; wr_ch = 3'd0; wr_duty = 8'd2; end
        end
        wr_en = 1'b0;
        check_val("shd_coin_0", h, 7);
        count_win(10);
        check_val("shd_coin_1", hcnt[0], 7);
        check_val("shd_oor_ch2", hcnt[2], 10);
        count_win(10);
        check_val("shd_coin_2", hcnt[0], 2);

        // Freeze
        wait_done();
        tick_n(4);
        ena = 1'b0;
        tick_n(1);
        snap = pwm_out;
        for (int j = 0; j < 20; j++) begin
            @(negedge clk);
            check_val("frz_hold", 32'(pwm_out), 32'(snap));
        end
        ena = 1'b1;
        gap_to_done(g);
        check_val("frz_resume", g, 6);

        // Randomized traffic against the model
        for (int s = 0; s < 40; s++) begin
            cfg_div    = DIV_W'($urandom_range(0, 3));
            cfg_period = CNT_W'($urandom_range(0, 15));
            cfg_center = 1'($urandom_range(0, 1));
            cfg_pol    = NCH'($urandom);
            for (int c = 0; c < 60; c++) begin
                ena     = ($urandom_range(0, 9) != 0);
                wr_en   = ($urandom_range(0, 9) < 3);
                wr_ch   = CH_W'($urandom_range(0, 7));
                wr_duty = CNT_W'($urandom_range(0, 17));
                @(negedge clk);
            end
        end
        wr_en = 1'b0;
        ena   = 1'b1;

        // Asynchronous reset mid-period
        cfg_pol = 6'b010101;
        tick_n(3);
        #2 rst = 1'b1;
        #1;
        check_val("arst_pwm", 32'(pwm_out), 32'd0);
        check_val("arst_done", 32'(period_done), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        tick_n(40);
        check_val("arst_shadow", 32'(pwm_out), 32'(6'b010101));

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
